// File: rtl/hatch_pkg.sv
// Shared types and defaults for the egg-hatch controller.
package hatch_pkg;

  localparam int NUM_W               = 4;
  localparam int NUM_STAGES_DEFAULT  = 12;
  localparam int STAGE_TICKS_DEFAULT = 2000;
  localparam int FAIL_TICKS_DEFAULT  = 5000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

endpackage

// File: rtl/hatch_timer.sv
// Terminal-count timer: a down-counter that loads TICKS-1 on clear and
// reloads itself after reaching zero, so tc is high on every TICKS-th
// enabled cycle. A cleared timer has "zero ticks elapsed".
module hatch_timer #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int W = $clog2(TICKS);
  localparam logic [W-1:0] LOAD = W'(TICKS - 1);

  logic [W-1:0] cnt;

  // Count down while enabled, reload on clear or after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? LOAD : cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/hatch_ctrl.sv
// Egg-hatch sequencer feeding the dot-matrix display.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | display blank, waiting for start
//   S_RUN   | stages advance on in-range temperature, faults counted
//   S_PAUSE | everything frozen, temp alarm still tracks the sensor
//   S_DONE  | last stage shown, done raised, start restarts
//   S_FAIL  | temperature abort, alarm latched, start returns to idle
module hatch_ctrl
  import hatch_pkg::*;
#(
  parameter int STAGE_TICKS = STAGE_TICKS_DEFAULT,
  parameter int FAIL_TICKS  = FAIL_TICKS_DEFAULT,
  parameter int NUM_STAGES  = NUM_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic             pause_p,
  input  logic             temp_ok,
  output logic [NUM_W-1:0] num,
  output logic             st,
  output logic             temp,
  output logic             done,
  output logic             fail
);

  localparam logic [NUM_W-1:0] LAST = NUM_W'(NUM_STAGES - 1);

  state_t           state_q, state_d;
  logic [NUM_W-1:0] num_d;
  logic             st_d, temp_d, done_d, fail_d;

  logic start_go;
  logic stage_en, stage_tc;
  logic fail_en, fail_tc, fail_clr;

  // A start pulse only matters where it changes state; in RUN/PAUSE it is ignored.
  assign start_go = start_p && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign stage_en = (state_q == S_RUN) && temp_ok;
  assign fail_en  = (state_q == S_RUN) && !temp_ok;
  // Any in-range RUN cycle breaks the run of consecutive faults.
  assign fail_clr = start_go || stage_en;

  hatch_timer #(.TICKS(STAGE_TICKS)) u_stage_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stage_en),
    .clr   (start_go),
    .tc    (stage_tc)
  );

  hatch_timer #(.TICKS(FAIL_TICKS)) u_fail_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fail_en),
    .clr   (fail_clr),
    .tc    (fail_tc)
  );

  // Next state and next output values; outputs follow the state being entered.
  always_comb begin
    state_d = state_q;
    num_d   = num;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d = S_RUN;
          num_d   = '0;
        end
      end
      S_RUN: begin
        if (temp_ok) begin
          if (stage_tc) begin
            if (num == LAST) state_d = S_DONE;
            else             num_d   = num + 1'b1;
          end
        end else if (fail_tc) begin
          state_d = S_FAIL;
        end
        // The RUN cycle carrying the pause pulse still counts; DONE/FAIL take precedence.
        if (state_d == S_RUN && pause_p) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause_p) state_d = S_RUN;
      end
      S_DONE: begin
        if (start_p) begin
          state_d = S_RUN;
          num_d   = '0;
        end
      end
      S_FAIL: begin
        if (start_p) begin
          state_d = S_IDLE;
          num_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        num_d   = '0;
      end
    endcase

    st_d   = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    fail_d = (state_d == S_FAIL);
    case (state_d)
      S_RUN, S_PAUSE: temp_d = !temp_ok;
      S_FAIL:         temp_d = 1'b1;
      default:        temp_d = 1'b0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      num     <= '0;
      st      <= 1'b0;
      temp    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      num     <= num_d;
      st      <= st_d;
      temp    <= temp_d;
      done    <= done_d;
      fail    <= fail_d;
    end
  end

endmodule

// File: tb/tb_hatch_ctrl.sv
// Directed bench for hatch_ctrl with STAGE_TICKS=4, FAIL_TICKS=3, NUM_STAGES=12.
module tb_hatch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_p;
  logic       pause_p;
  logic       temp_ok;
  logic [3:0] num;
  logic       st;
  logic       temp;
  logic       done;
  logic       fail;

  int passed = 0;
  int total  = 0;

  hatch_ctrl #(
    .STAGE_TICKS (4),
    .FAIL_TICKS  (3),
    .NUM_STAGES  (12)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_p (start_p),
    .pause_p (pause_p),
    .temp_ok (temp_ok),
    .num     (num),
    .st      (st),
    .temp    (temp),
    .done    (done),
    .fail    (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; outputs of that edge are settled afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_p = 1'b0; pause_p = 1'b0; temp_ok = 1'b1;
    #12;
    total++; if (st   !== 1'b0) $display("FAIL reset_st got %b want 0", st);     else passed++;
    total++; if (num  !== 4'd0) $display("FAIL reset_num got %0d want 0", num);  else passed++;
    total++; if (temp !== 1'b0) $display("FAIL reset_temp got %b want 0", temp); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (fail !== 1'b0) $display("FAIL reset_fail got %b want 0", fail); else passed++;
    rst_n = 1'b1;
    step();
    total++; if (st !== 1'b0) $display("FAIL idle_st got %b want 0", st); else passed++;
  endtask

  task automatic test_full_run();
    start_p = 1'b1; step(); start_p = 1'b0;
    total++; if (st   !== 1'b1) $display("FAIL start_st got %b want 1", st);     else passed++;
    total++; if (num  !== 4'd0) $display("FAIL start_num got %0d want 0", num);  else passed++;
    for (int c = 1; c <= 48; c++) begin
      step();
      if (c < 48) begin
        total++; if (num !== 4'(c / 4)) $display("FAIL run_num c=%0d got %0d want %0d", c, num, c / 4); else passed++;
        total++; if (done !== 1'b0) $display("FAIL run_done_early c=%0d got %b want 0", c, done); else passed++;
      end else begin
        total++; if (done !== 1'b1) $display("FAIL run_done c=48 got %b want 1", done); else passed++;
        total++; if (num !== 4'd11) $display("FAIL run_done_num got %0d want 11", num); else passed++;
      end
    end
  endtask

  task automatic test_done_restart();
    step();
    total++; if (done !== 1'b1 || num !== 4'd11 || st !== 1'b1)
      $display("FAIL done_hold got done=%b num=%0d st=%b want 1/11/1", done, num, st); else passed++;
    start_p = 1'b1; step(); start_p = 1'b0;
    total++; if (num  !== 4'd0) $display("FAIL restart_num got %0d want 0", num);  else passed++;
    total++; if (done !== 1'b0) $display("FAIL restart_done got %b want 0", done); else passed++;
    total++; if (st   !== 1'b1) $display("FAIL restart_st got %b want 1", st);     else passed++;
  endtask

  task automatic test_temp_dip();
    step(); step();
    total++; if (temp !== 1'b0) $display("FAIL dip_temp_pre got %b want 0", temp); else passed++;
    temp_ok = 1'b0;
    step();
    total++; if (temp !== 1'b1) $display("FAIL dip_temp1 got %b want 1", temp); else passed++;
    step();
    total++; if (temp !== 1'b1) $display("FAIL dip_temp2 got %b want 1", temp); else passed++;
    temp_ok = 1'b1;
    step();
    total++; if (temp !== 1'b0) $display("FAIL dip_temp_clr got %b want 0", temp); else passed++;
    total++; if (num  !== 4'd0) $display("FAIL dip_num_ext got %0d want 0", num);  else passed++;
    total++; if (fail !== 1'b0) $display("FAIL dip_fail got %b want 0", fail);     else passed++;
    step();
    total++; if (num  !== 4'd1) $display("FAIL dip_num_adv got %0d want 1", num);  else passed++;
  endtask

  task automatic test_fail();
    temp_ok = 1'b0;
    step();
    total++; if (fail !== 1'b0 || temp !== 1'b1) $display("FAIL fail_c1 got fail=%b temp=%b want 0/1", fail, temp); else passed++;
    step();
    total++; if (fail !== 1'b0) $display("FAIL fail_c2 got %b want 0", fail); else passed++;
    step();
    total++; if (fail !== 1'b1) $display("FAIL fail_enter got %b want 1", fail); else passed++;
    total++; if (temp !== 1'b1 || num !== 4'd1 || st !== 1'b1)
      $display("FAIL fail_outs got temp=%b num=%0d st=%b want 1/1/1", temp, num, st); else passed++;
    temp_ok = 1'b1;
    step(); step();
    total++; if (fail !== 1'b1 || temp !== 1'b1 || num !== 4'd1)
      $display("FAIL fail_latched got fail=%b temp=%b num=%0d want 1/1/1", fail, temp, num); else passed++;
    start_p = 1'b1; step(); start_p = 1'b0;
    total++; if ({st, num, temp, done, fail} !== 8'd0)
      $display("FAIL fail_clear got st=%b num=%0d temp=%b done=%b fail=%b want all 0", st, num, temp, done, fail); else passed++;
    step();
    total++; if (st !== 1'b0) $display("FAIL fail_idle got st=%b want 0", st); else passed++;
  endtask

  task automatic test_start_pause_idle();
    start_p = 1'b1; pause_p = 1'b1; step(); start_p = 1'b0; pause_p = 1'b0;
    total++; if (st !== 1'b1 || num !== 4'd0) $display("FAIL sp_start got st=%b num=%0d want 1/0", st, num); else passed++;
    step(); step(); step(); step();
    total++; if (num !== 4'd1) $display("FAIL sp_is_run got num=%0d want 1", num); else passed++;
  endtask

  task automatic test_pause();
    logic exp_temp;
    for (int i = 0; i < 10; i++) step();
    total++; if (num !== 4'd3) $display("FAIL pause_pre_num got %0d want 3", num); else passed++;
    pause_p = 1'b1; step(); pause_p = 1'b0;
    total++; if (num !== 4'd3) $display("FAIL pause_enter_num got %0d want 3", num); else passed++;
    for (int i = 0; i < 20; i++) begin
      exp_temp = (i >= 5 && i < 12);
      temp_ok = !exp_temp;
      step();
      total++; if (num !== 4'd3) $display("FAIL pause_num i=%0d got %0d want 3", i, num); else passed++;
      total++; if (temp !== exp_temp) $display("FAIL pause_temp i=%0d got %b want %b", i, temp, exp_temp); else passed++;
      total++; if (fail !== 1'b0) $display("FAIL pause_fail i=%0d got %b want 0", i, fail); else passed++;
    end
    pause_p = 1'b1; step(); pause_p = 1'b0;
    total++; if (num !== 4'd3) $display("FAIL resume_num got %0d want 3", num); else passed++;
    step();
    total++; if (num !== 4'd4) $display("FAIL resume_adv got %0d want 4", num); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 14; i++) step();
    total++; if (num !== 4'd7) $display("FAIL ar_pre_num got %0d want 7", num); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({st, num, temp, done, fail} !== 8'd0)
      $display("FAIL ar_clear got st=%b num=%0d temp=%b done=%b fail=%b want all 0", st, num, temp, done, fail); else passed++;
    #3;
    rst_n = 1'b1;
    step();
    total++; if (st !== 1'b0 || num !== 4'd0) $display("FAIL ar_idle got st=%b num=%0d want 0/0", st, num); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_done_restart();
    test_temp_dip();
    test_fail();
    test_start_pause_idle();
    test_pause();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
